router_fifo: RTL and testbench

- One 16-deep by 9-bit output FIFO per destination port of the 1x3 router; three instances sit directly downstream of the synchroniser.
- Each instance takes its one-hot write_enb bit, its soft_reset line and its data bytes, and drives full/empty back to the synchroniser.
- Bit 8 of every entry tags the header byte (lfd_state). A packet-length counter follows header payload length plus parity while the packet is read out.

---
 rtl/router_fifo.sv | 92 +++++++++
 tb/tb_router_fifo.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/router_fifo.sv
// Per-port output FIFO of the 1x3 router: 16x9 storage with header tag in bit 8,
// registered read data, and a packet-length counter that tracks the packet being read out.
module router_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic             busy
);

    localparam int AW    = PTR_W - 1;
    localparam int CNT_W = WIDTH - 1;

    logic [WIDTH:0]     r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [WIDTH-1:0]   r_data_out;
    logic [CNT_W-1:0]   r_pkt_cnt;

    logic               w_full;
    logic               w_empty;
    logic               w_wr_acc;
    logic               w_rd_acc;
    logic               w_clear;
    logic [WIDTH:0]     w_rd_word;
    logic [CNT_W-1:0]   w_pkt_cnt_nxt;

    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_wr_acc = write_enb && !w_full;
    assign w_rd_acc = read_enb && !w_empty;
    assign w_clear  = !resetn || soft_reset;

    assign w_rd_word = r_mem[r_rd_ptr[AW-1:0]];

    // Header carries payload length in [WIDTH-1:2]; +1 accounts for the trailing parity byte.
    always_comb begin
        w_pkt_cnt_nxt = r_pkt_cnt;
        if (w_rd_word[WIDTH]) begin
            w_pkt_cnt_nxt = CNT_W'(w_rd_word[WIDTH-1:2]) + CNT_W'(1);
        end else if (r_pkt_cnt != '0) begin
            w_pkt_cnt_nxt = r_pkt_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (w_clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_acc) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {lfd_state, data_in};
        end
    end

    always_ff @(posedge clock) begin
        if (w_clear) begin
            r_wr_ptr <= '0;
        end else if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (w_clear) begin
            r_rd_ptr   <= '0;
            r_data_out <= '0;
            r_pkt_cnt  <= '0;
        end else if (w_rd_acc) begin
            r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
            r_data_out <= w_rd_word[WIDTH-1:0];
            r_pkt_cnt  <= w_pkt_cnt_nxt;
        end
    end

    assign data_out = r_data_out;
    assign full     = w_full;
    assign empty    = w_empty;
    assign busy     = (r_pkt_cnt != '0);

endmodule

// File: tb/tb_router_fifo.sv
// Directed bench for router_fifo: fill/drain, packet counter, flush, simultaneous
// access at the full/empty boundaries, pointer wrap and mid-packet reset.
module tb_router_fifo;

    logic       clock;
    logic       resetn;
    logic       soft_reset;
    logic       write_enb;
    logic       read_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    router_fifo dut (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, sample 1 time unit later.
    task automatic cyc(input logic we, input logic re, input logic lfd, input logic [7:0] d);
        write_enb = we;
        read_enb  = re;
        lfd_state = lfd;
        data_in   = d;
        @(posedge clock);
        #1;
        write_enb = 1'b0;
        read_enb  = 1'b0;
        lfd_state = 1'b0;
        data_in   = 8'h00;
    endtask

    initial begin
        resetn     = 1'b0;
        soft_reset = 1'b0;
        write_enb  = 1'b0;
        read_enb   = 1'b0;
        lfd_state  = 1'b0;
        data_in    = 8'h00;
        cyc(0, 0, 0, 8'h00);
        cyc(0, 0, 0, 8'h00);
        chk("rst_empty", 9'(empty), 9'd1);
        chk("rst_full", 9'(full), 9'd0);
        chk("rst_busy", 9'(busy), 9'd0);
        chk("rst_dout", 9'(data_out), 9'h00);
        resetn = 1'b1;

        // 1: fill to 16, drop a 17th, drain in order
        for (int i = 1; i <= 16; i++) begin
            cyc(1, 0, 0, 8'(i));
            if (i == 15) chk("t1_not_full_15", 9'(full), 9'd0);
        end
        chk("t1_full_16", 9'(full), 9'd1);
        cyc(1, 0, 0, 8'hFF);
        chk("t1_full_after_drop", 9'(full), 9'd1);
        for (int i = 1; i <= 16; i++) begin
            cyc(0, 1, 0, 8'h00);
            chk("t1_drain_data", 9'(data_out), 9'(i));
        end
        chk("t1_empty", 9'(empty), 9'd1);
        cyc(0, 1, 0, 8'h00);
        chk("t1_rd_empty_hold", 9'(data_out), 9'h10);
        chk("t1_still_empty", 9'(empty), 9'd1);

        // 2: header 0x0C -> length 3, counter 4
        cyc(1, 0, 1, 8'h0C);
        cyc(1, 0, 0, 8'hA1);
        cyc(1, 0, 0, 8'hA2);
        cyc(1, 0, 0, 8'hA3);
        cyc(1, 0, 0, 8'h5A);
        chk("t2_busy_before", 9'(busy), 9'd0);
        cyc(0, 1, 0, 8'h00);
        chk("t2_hdr_data", 9'(data_out), 9'h0C);
        chk("t2_hdr_busy", 9'(busy), 9'd1);
        cyc(0, 1, 0, 8'h00);
        chk("t2_p1_busy", 9'(busy), 9'd1);
        cyc(0, 1, 0, 8'h00);
        chk("t2_p2_busy", 9'(busy), 9'd1);
        cyc(0, 1, 0, 8'h00);
        chk("t2_p3_data", 9'(data_out), 9'hA3);
        chk("t2_p3_busy", 9'(busy), 9'd1);
        cyc(0, 1, 0, 8'h00);
        chk("t2_par_data", 9'(data_out), 9'h5A);
        chk("t2_par_busy", 9'(busy), 9'd0);
        chk("t2_empty", 9'(empty), 9'd1);

        // zero-length header: counter 1, busy until parity read
        cyc(1, 0, 1, 8'h03);
        cyc(1, 0, 0, 8'h77);
        cyc(0, 1, 0, 8'h00);
        chk("t2_len0_busy", 9'(busy), 9'd1);
        cyc(0, 1, 0, 8'h00);
        chk("t2_len0_par", 9'(data_out), 9'h77);
        chk("t2_len0_idle", 9'(busy), 9'd0);

        // header read while busy reloads (0x04 -> 2, then 0x0C -> 4)
        cyc(1, 0, 1, 8'h04);
        cyc(1, 0, 1, 8'h0C);
        cyc(1, 0, 0, 8'hC1);
        cyc(1, 0, 0, 8'hC2);
        cyc(1, 0, 0, 8'hC3);
        cyc(1, 0, 0, 8'hC4);
        cyc(0, 1, 0, 8'h00);
        cyc(0, 1, 0, 8'h00);
        chk("t2_reload_hdr", 9'(data_out), 9'h0C);
        cyc(0, 1, 0, 8'h00);
        cyc(0, 1, 0, 8'h00);
        chk("t2_reload_busy_mid", 9'(busy), 9'd1);
        cyc(0, 1, 0, 8'h00);
        chk("t2_reload_busy_c3", 9'(busy), 9'd1);
        cyc(0, 1, 0, 8'h00);
        chk("t2_reload_end_data", 9'(data_out), 9'hC4);
        chk("t2_reload_end_busy", 9'(busy), 9'd0);

        // 3: soft_reset with 5 held and busy, concurrent write discarded
        cyc(1, 0, 1, 8'h10);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 8'(8'h21 + i));
        cyc(0, 1, 0, 8'h00);
        cyc(1, 0, 0, 8'h25);
        chk("t3_pre_busy", 9'(busy), 9'd1);
        chk("t3_pre_dout", 9'(data_out), 9'h10);
        soft_reset = 1'b1;
        cyc(1, 0, 0, 8'h99);
        soft_reset = 1'b0;
        chk("t3_empty", 9'(empty), 9'd1);
        chk("t3_full", 9'(full), 9'd0);
        chk("t3_dout", 9'(data_out), 9'h00);
        chk("t3_busy", 9'(busy), 9'd0);
        cyc(0, 1, 0, 8'h00);
        chk("t3_no_store_dout", 9'(data_out), 9'h00);
        chk("t3_no_store_empty", 9'(empty), 9'd1);

        // 4: simultaneous write+read at full, then at empty
        for (int i = 0; i < 16; i++) cyc(1, 0, 0, 8'(8'h31 + i));
        chk("t4_full", 9'(full), 9'd1);
        cyc(1, 1, 0, 8'hEE);
        chk("t4_full_after_both", 9'(full), 9'd0);
        chk("t4_oldest", 9'(data_out), 9'h31);
        for (int i = 0; i < 15; i++) begin
            cyc(0, 1, 0, 8'h00);
            chk("t4_drain_data", 9'(data_out), 9'(8'h32 + i));
        end
        chk("t4_occ15_empty", 9'(empty), 9'd1);
        cyc(1, 1, 0, 8'h55);
        chk("t4_empty_both_dout", 9'(data_out), 9'h40);
        chk("t4_empty_both_occ", 9'(empty), 9'd0);
        cyc(0, 1, 0, 8'h00);
        chk("t4_empty_both_wr", 9'(data_out), 9'h55);
        chk("t4_empty_after", 9'(empty), 9'd1);

        // 5: 40 write/read pairs at one-entry occupancy, crossing the pointer wrap
        cyc(1, 0, 0, 8'h80);
        for (int i = 0; i < 40; i++) begin
            cyc(1, 1, 0, 8'(8'h81 + i));
            chk("t5_order", 9'(data_out), 9'(8'h80 + i));
            chk("t5_occ1", 9'(empty), 9'd0);
        end
        cyc(0, 1, 0, 8'h00);
        chk("t5_last", 9'(data_out), 9'hA8);
        chk("t5_empty", 9'(empty), 9'd1);

        // 6: hard reset mid-packet
        cyc(1, 0, 1, 8'h18);
        for (int i = 0; i < 7; i++) cyc(1, 0, 0, 8'(8'hD1 + i));
        cyc(0, 1, 0, 8'h00);
        chk("t6_pre_busy", 9'(busy), 9'd1);
        chk("t6_pre_dout", 9'(data_out), 9'h18);
        resetn = 1'b0;
        cyc(0, 0, 0, 8'h00);
        resetn = 1'b1;
        chk("t6_empty", 9'(empty), 9'd1);
        chk("t6_full", 9'(full), 9'd0);
        chk("t6_busy", 9'(busy), 9'd0);
        chk("t6_dout", 9'(data_out), 9'h00);
        cyc(1, 0, 0, 8'h42);
        cyc(0, 1, 0, 8'h00);
        chk("t6_fresh_data", 9'(data_out), 9'h42);
        chk("t6_fresh_busy", 9'(busy), 9'd0);
        chk("t6_fresh_empty", 9'(empty), 9'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
